// File: rtl/dino_pkg.sv
// Shared definitions for the Dino jump datapath and the sprite renderer.
package dino_pkg;

    typedef enum logic [1:0] {
        GROUND,
        RISE,
        HANG,
        FALL
    } jump_state_t;

    localparam int DINO_OFFSET_W    = 6;
    localparam int DINO_MAX_HEIGHT  = 24;
    localparam int DINO_V0          = 6;
    localparam int DINO_GRAVITY     = 1;
    localparam int DINO_HANG_FRAMES = 4;

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector on a level input with a configurable reset value.
module rise_edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) prev <= RESET_VAL;
        else     prev <= level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/jump_trajectory.sv
// Turns a jump request edge into a per-frame rise / hang / fall sprite offset.
module jump_trajectory
    import dino_pkg::*;
#(
    parameter int OFFSET_W    = DINO_OFFSET_W,
    parameter int MAX_HEIGHT  = DINO_MAX_HEIGHT,
    parameter int V0          = DINO_V0,
    parameter int GRAVITY     = DINO_GRAVITY,
    parameter int HANG_FRAMES = DINO_HANG_FRAMES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                jump_req,
    input  logic                frame_tick,
    output logic [OFFSET_W-1:0] dino_y_offset,
    output logic                airborne,
    output logic                landed
);

    localparam int HC_W = (HANG_FRAMES > 1) ? $clog2(HANG_FRAMES) : 1;

    localparam logic [OFFSET_W-1:0] MAX_W   = OFFSET_W'(MAX_HEIGHT);
    localparam logic [OFFSET_W-1:0] V0_W    = OFFSET_W'(V0);
    localparam logic [OFFSET_W-1:0] G_W     = OFFSET_W'(GRAVITY);
    localparam logic [OFFSET_W:0]   MAX_EXT = (OFFSET_W+1)'(MAX_HEIGHT);
    localparam logic [OFFSET_W:0]   V0_EXT  = (OFFSET_W+1)'(V0);
    localparam logic [OFFSET_W:0]   G_EXT   = (OFFSET_W+1)'(GRAVITY);
    localparam logic [HC_W-1:0]     HC_LAST = HC_W'(HANG_FRAMES - 1);

    jump_state_t         state, state_n;
    logic [OFFSET_W-1:0] offset_n;
    logic [OFFSET_W-1:0] vel, vel_n;
    logic [HC_W-1:0]     hang_cnt, hang_n;
    logic                landed_n;
    logic                start;
    logic [OFFSET_W:0]   sum;
    logic [OFFSET_W:0]   vel_inc;

    // Resets high so a request held through reset is not seen as an edge.
    rise_edge_detect #(
        .RESET_VAL(1'b1)
    ) u_edge (
        .clk  (clk),
        .rst  (rst),
        .level(jump_req),
        .rise (start)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= GROUND;
            dino_y_offset <= '0;
            vel           <= '0;
            hang_cnt      <= '0;
            airborne      <= 1'b0;
            landed        <= 1'b0;
        end else begin
            state         <= state_n;
            dino_y_offset <= offset_n;
            vel           <= vel_n;
            hang_cnt      <= hang_n;
            airborne      <= (state_n != GROUND);
            landed        <= landed_n;
        end
    end

    always_comb begin
        state_n  = state;
        offset_n = dino_y_offset;
        vel_n    = vel;
        hang_n   = hang_cnt;
        landed_n = 1'b0;
        // One extra bit so offset+vel cannot wrap before the clamp.
        sum      = {1'b0, dino_y_offset} + {1'b0, vel};
        vel_inc  = {1'b0, vel} + G_EXT;

        unique case (state)
            GROUND: begin
                if (start) begin
                    state_n = RISE;
                    vel_n   = V0_W;
                end
            end
            RISE: begin
                if (frame_tick) begin
                    offset_n = (sum >= MAX_EXT) ? MAX_W
                                                : sum[OFFSET_W-1:0];
                    if (vel <= G_W || sum >= MAX_EXT) begin
                        state_n = HANG;
                        hang_n  = '0;
                    end else begin
                        vel_n = vel - G_W;
                    end
                end
            end
            HANG: begin
                if (frame_tick) begin
                    if (hang_cnt == HC_LAST) begin
                        state_n = FALL;
                        vel_n   = G_W;
                    end else begin
                        hang_n = hang_cnt + 1'b1;
                    end
                end
            end
            FALL: begin
                if (frame_tick) begin
                    if (dino_y_offset <= vel) begin
                        offset_n = '0;
                        state_n  = GROUND;
                        landed_n = 1'b1;
                    end else begin
                        offset_n = dino_y_offset - vel;
                        vel_n    = (vel_inc >= V0_EXT) ? V0_W
                                                       : vel_inc[OFFSET_W-1:0];
                    end
                end
            end
            default: state_n = GROUND;
        endcase
    end

endmodule

// File: tb/tb_jump_trajectory.sv
// Directed bench for jump_trajectory: default arc, retrigger rules, clamp, reset.
module tb_jump_trajectory;
    import dino_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       jump_req = 1'b0;
    logic       frame_tick = 1'b0;
    logic       jump_req2 = 1'b0;
    logic       frame_tick2 = 1'b0;
    logic [5:0] off1, off2;
    logic       air1, air2, land1, land2;

    int checks = 0;
    int failures = 0;

    int arc_def[16] = '{6, 11, 15, 18, 20, 21, 21, 21, 21, 21,
                        20, 18, 15, 11, 6, 0};
    int arc_clamp[14] = '{10, 19, 24, 24, 24, 24, 24,
                          23, 21, 18, 14, 9, 3, 0};

    always #5 clk = ~clk;

    jump_trajectory dut (
        .clk          (clk),
        .rst          (rst),
        .jump_req     (jump_req),
        .frame_tick   (frame_tick),
        .dino_y_offset(off1),
        .airborne     (air1),
        .landed       (land1)
    );

    jump_trajectory #(
        .OFFSET_W   (6),
        .MAX_HEIGHT (24),
        .V0         (10),
        .GRAVITY    (1),
        .HANG_FRAMES(4)
    ) dut_clamp (
        .clk          (clk),
        .rst          (rst),
        .jump_req     (jump_req2),
        .frame_tick   (frame_tick2),
        .dino_y_offset(off2),
        .airborne     (air2),
        .landed       (land2)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int cur_off(input bit w);
        return w ? int'(off2) : int'(off1);
    endfunction

    function automatic int cur_air(input bit w);
        return w ? int'(air2) : int'(air1);
    endfunction

    function automatic int cur_land(input bit w);
        return w ? int'(land2) : int'(land1);
    endfunction

    // Steps a whole arc with 8-cycle frame spacing, checking every tick.
    task automatic run_arc(input string name, input bit w, input int n,
                           input bit toggle);
        int air_ticks;
        int exp;
        air_ticks = 0;
        for (int i = 0; i < n; i++) begin
            if (toggle && i == 7) begin
                jump_req = 1'b1;
                cyc();
                jump_req = 1'b0;
                repeat (6) cyc();
            end else begin
                repeat (7) cyc();
            end
            if (cur_air(w) == 1) air_ticks++;
            if (toggle && i == n - 1) jump_req = 1'b1;
            if (w) frame_tick2 = 1'b1;
            else   frame_tick = 1'b1;
            cyc();
            frame_tick  = 1'b0;
            frame_tick2 = 1'b0;
            exp = w ? arc_clamp[i] : arc_def[i];
            chk($sformatf("%s_off[%0d]", name, i), cur_off(w), exp);
            chk($sformatf("%s_air[%0d]", name, i), cur_air(w),
                (i < n - 1) ? 1 : 0);
            chk($sformatf("%s_land[%0d]", name, i), cur_land(w),
                (i == n - 1) ? 1 : 0);
        end
        cyc();
        chk({name, "_land_width"}, cur_land(w), 0);
        chk({name, "_air_ticks"}, air_ticks, n);
    endtask

    task automatic idle_ticks(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            repeat (7) cyc();
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            chk($sformatf("%s_air[%0d]", name, i), int'(air1), 0);
            chk($sformatf("%s_off[%0d]", name, i), int'(off1), 0);
            chk($sformatf("%s_land[%0d]", name, i), int'(land1), 0);
        end
    endtask

    initial begin
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk("rst_off", int'(off1), 0);
        chk("rst_air", int'(air1), 0);
        chk("rst_land", int'(land1), 0);
        chk("rst_off2", int'(off2), 0);

        // Single jump, request pulsed for 10 cycles.
        jump_req = 1'b1;
        cyc();
        chk("single_air_start", int'(air1), 1);
        chk("single_off_start", int'(off1), 0);
        repeat (9) cyc();
        jump_req = 1'b0;
        run_arc("single", 1'b0, 16, 1'b0);

        // Held request: one jump only, then retrigger after a drop.
        jump_req = 1'b1;
        cyc();
        chk("held_air_start", int'(air1), 1);
        run_arc("held", 1'b0, 16, 1'b0);
        idle_ticks("held_idle", 20);
        jump_req = 1'b0;
        cyc();
        jump_req = 1'b1;
        cyc();
        chk("retrig_air_start", int'(air1), 1);
        run_arc("retrig", 1'b0, 16, 1'b0);

        // Edges in HANG and on the landing tick are ignored.
        jump_req = 1'b0;
        cyc();
        jump_req = 1'b1;
        cyc();
        chk("tog_air_start", int'(air1), 1);
        jump_req = 1'b0;
        run_arc("tog", 1'b0, 16, 1'b1);
        idle_ticks("tog_idle", 3);
        jump_req = 1'b0;

        // Edge and tick together in GROUND: no step on that tick.
        cyc();
        jump_req   = 1'b1;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("simul_off", int'(off1), 0);
        chk("simul_air", int'(air1), 1);
        jump_req = 1'b0;
        run_arc("simul", 1'b0, 16, 1'b0);

        // Ceiling clamp with V0=10.
        jump_req2 = 1'b1;
        cyc();
        chk("clamp_air_start", int'(air2), 1);
        jump_req2 = 1'b0;
        run_arc("clamp", 1'b1, 14, 1'b0);

        // Reset during RISE with the request released.
        jump_req = 1'b1;
        cyc();
        jump_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            repeat (7) cyc();
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
        end
        chk("rise_off_pre_rst", int'(off1), 11);
        rst = 1'b1;
        cyc();
        chk("mid_rst_off", int'(off1), 0);
        chk("mid_rst_air", int'(air1), 0);
        chk("mid_rst_land", int'(land1), 0);
        rst = 1'b0;
        cyc();
        chk("mid_rst_after_air", int'(air1), 0);

        // Reset with the request held high: no jump afterwards.
        jump_req = 1'b1;
        cyc();
        chk("held_rst_air_start", int'(air1), 1);
        repeat (7) cyc();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("held_rst_off_pre", int'(off1), 6);
        rst = 1'b1;
        cyc();
        chk("held_rst_off", int'(off1), 0);
        chk("held_rst_air", int'(air1), 0);
        chk("held_rst_land", int'(land1), 0);
        rst = 1'b0;
        idle_ticks("held_rst_idle", 20);
        jump_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
